// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: datapath width, special
// instruction encodings and the fetch-stage state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC and PC+4
// plus a valid flag. Flush only drops valid; the payload is retained.
module if_id_reg #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [31:0]     fetch_instr,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_pc_plus4,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);
  import riscv_pkg::*;

  // Register update: reset beats flush, flush beats load (squashes capture).
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= fetch_instr;
      pc       <= fetch_pc;
      pc_plus4 <= fetch_pc_plus4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address, and feeds the IF/ID register with back-pressure, redirect/flush,
// halt on ECALL/EBREAK and fault on bad fetch or redirect addresses.
module if_stage #(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_WORDS = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] a,
  input  logic [31:0]     rd,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            halted,
  output logic            fault
);
  import riscv_pkg::*;

  localparam logic [XLEN-3:0] IMEM_LIMIT = (XLEN-2)'(IMEM_WORDS);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next, pc_plus4;
  logic            accept, misaligned, out_of_range, is_system;
  logic            load, flush;

  assign a            = pc;
  assign pc_plus4     = pc + XLEN'(4);
  assign accept       = !id_valid || id_ready;
  assign misaligned   = redirect_pc[1:0] != 2'b00;
  assign out_of_range = pc[XLEN-1:2] >= IMEM_LIMIT;
  assign is_system    = (rd == ECALL_INSTR) || (rd == EBREAK_INSTR);

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next-state selection; HALT and FAULT are left only through reset.
  always_comb begin
    state_next = state;
    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect_valid) begin
          if (misaligned) state_next = FAULT;
        end else if (accept) begin
          if (out_of_range)   state_next = FAULT;
          else if (is_system) state_next = HALT;
        end
      end
      default: state_next = state;
    endcase
  end

  // Datapath controls: next PC, IF/ID load/flush and status outputs.
  always_comb begin
    pc_next = pc;
    load    = 1'b0;
    flush   = 1'b0;
    halted  = (state == HALT);
    fault   = (state == FAULT);
    unique case (state)
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (!misaligned) pc_next = redirect_pc;
        end else if (accept) begin
          if (out_of_range) begin
            flush = id_ready;
          end else begin
            load = 1'b1;
            if (!is_system) pc_next = pc_plus4;
          end
        end
      end
      HALT, FAULT: flush = id_ready;
      default: ;
    endcase
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .flush          (flush),
    .fetch_instr    (rd),
    .fetch_pc       (pc),
    .fetch_pc_plus4 (pc_plus4),
    .valid          (id_valid),
    .instr          (id_instr),
    .pc             (id_pc),
    .pc_plus4       (id_pc_plus4)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 4-word combinational instruction memory.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        halted;
  logic        fault;

  logic [31:0] mem [4];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign rd = (a[31:2] < 30'd4) ? mem[a[3:2]] : 32'h0000_0013;

  if_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .a             (a),
    .rd            (rd),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .halted        (halted),
    .fault         (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled and inputs changed 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, id_valid}, 32'd1);
    check({tag, ".instr"}, id_instr, instr);
    check({tag, ".pc"}, id_pc, pc);
    check({tag, ".pc4"}, id_pc_plus4, pc + 32'd4);
  endtask

  initial begin
    mem[0] = 32'h0050_0113;
    mem[1] = 32'h00c0_0193;
    mem[2] = 32'h01e0_0113;
    mem[3] = 32'h0220_2423;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    reset = 1'b0;
    step();

    // Reset state
    check("rst.a", a, 32'h0);
    check("rst.valid", {31'd0, id_valid}, 32'd0);
    check("rst.instr", id_instr, 32'h0000_0013);
    check("rst.pc", id_pc, 32'h0);
    check("rst.pc4", id_pc_plus4, 32'h0);
    check("rst.halted", {31'd0, halted}, 32'd0);
    check("rst.fault", {31'd0, fault}, 32'd0);

    // Basic sequencing through the image, then out-of-range fault
    reset = 1'b1;
    step();
    check("boot.valid", {31'd0, id_valid}, 32'd0);
    check("boot.a", a, 32'h0);
    step(); check_id("seq0", 32'h0050_0113, 32'h0);
    step(); check_id("seq1", 32'h00c0_0193, 32'h4);
    step(); check_id("seq2", 32'h01e0_0113, 32'h8);
    step(); check_id("seq3", 32'h0220_2423, 32'hC);
    check("seq3.a", a, 32'h10);
    step();
    check("oob.fault", {31'd0, fault}, 32'd1);
    check("oob.valid", {31'd0, id_valid}, 32'd0);
    check("oob.a", a, 32'h10);
    check("oob.instr", id_instr, 32'h0220_2423);

    // Stall after the first capture
    do_reset();
    id_ready = 1'b1;
    step();
    step(); check_id("stall0", 32'h0050_0113, 32'h0);
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall.instr", id_instr, 32'h0050_0113);
      check("stall.valid", {31'd0, id_valid}, 32'd1);
      check("stall.a", a, 32'h4);
    end
    id_ready = 1'b1;
    step(); check_id("unstall", 32'h00c0_0193, 32'h4);
    check("unstall.a", a, 32'h8);

    // Redirect while decode is stalled
    do_reset();
    id_ready = 1'b1;
    step();
    step(); check_id("rdr0", 32'h0050_0113, 32'h0);
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    step();
    check("rdr.valid", {31'd0, id_valid}, 32'd0);
    check("rdr.a", a, 32'h8);
    redirect_valid = 1'b0;
    step(); check_id("rdr1", 32'h01e0_0113, 32'h8);
    check("rdr1.a", a, 32'hC);

    // Misaligned redirect, then redirects ignored in FAULT
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    step();
    check("mis.fault", {31'd0, fault}, 32'd1);
    check("mis.valid", {31'd0, id_valid}, 32'd0);
    check("mis.a", a, 32'hC);
    for (int i = 0; i < 10; i++) begin
      redirect_valid = i[0];
      redirect_pc = 32'h0;
      step();
      check("mis.hold.valid", {31'd0, id_valid}, 32'd0);
      check("mis.hold.a", a, 32'hC);
      check("mis.hold.instr", id_instr, 32'h01e0_0113);
      check("mis.hold.fault", {31'd0, fault}, 32'd1);
    end
    redirect_valid = 1'b0;

    // Halt on ECALL at word 1
    mem[1] = 32'h0000_0073;
    do_reset();
    id_ready = 1'b1;
    step();
    step(); check_id("halt0", 32'h0050_0113, 32'h0);
    step(); check_id("halt1", 32'h0000_0073, 32'h4);
    check("halt.halted", {31'd0, halted}, 32'd1);
    check("halt.a", a, 32'h4);
    id_ready = 1'b0;
    step();
    check("halt.hold.valid", {31'd0, id_valid}, 32'd1);
    check("halt.hold.a", a, 32'h4);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    check("halt.drain.valid", {31'd0, id_valid}, 32'd0);
    check("halt.drain.a", a, 32'h4);
    check("halt.drain.halted", {31'd0, halted}, 32'd1);
    redirect_valid = 1'b0;
    step();
    check("halt.idle.valid", {31'd0, id_valid}, 32'd0);
    check("halt.idle.a", a, 32'h4);
    mem[1] = 32'h00c0_0193;

    // Reset in the middle of a stall
    do_reset();
    id_ready = 1'b1;
    step();
    step();
    step(); check_id("mid1", 32'h00c0_0193, 32'h4);
    id_ready = 1'b0;
    step();
    check("mid.stall.a", a, 32'h8);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid.rst.a", a, 32'h0);
    check("mid.rst.valid", {31'd0, id_valid}, 32'd0);
    check("mid.rst.instr", id_instr, 32'h0000_0013);
    check("mid.rst.halted", {31'd0, halted}, 32'd0);
    check("mid.rst.fault", {31'd0, fault}, 32'd0);
    id_ready = 1'b1;
    step();
    check("mid.boot.valid", {31'd0, id_valid}, 32'd0);
    step(); check_id("mid.restart", 32'h0050_0113, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
